// File: rtl/partial_sum_combiner_if.sv
// partial_sum_combiner_if
// Groups the beat handshake, the three partial-product buses and the result
// bus of partial_sum_combiner.
//   master : source/sink side (drives beats and out_ready, observes results)
//   slave  : combiner side (accepts beats, drives in_ready and results)
// Signals:
//   mode[1:0], in_valid, in_ready, in_last          beat handshake
//   int_in, frac1_in, frac2_in                      LANES x 2*WIDTH signed lanes
//   out_valid, out_ready                            result handshake
//   out_data                                        LANES x OUT_W signed lanes
//   sat_flag[LANES-1:0]                             per-lane clamp indicator
//   err                                             one-cycle illegal-sequence pulse
interface partial_sum_combiner_if #(
    parameter int LANES = 16,
    parameter int WIDTH = 8,
    parameter int OUT_W = 24
);
    logic [1:0]                 mode;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic [LANES*2*WIDTH-1:0]   int_in;
    logic [LANES*2*WIDTH-1:0]   frac1_in;
    logic [LANES*2*WIDTH-1:0]   frac2_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*OUT_W-1:0]     out_data;
    logic [LANES-1:0]           sat_flag;
    logic                       err;

    modport master (
        output mode, in_valid, in_last, int_in, frac1_in, frac2_in, out_ready,
        input  in_ready, out_valid, out_data, sat_flag, err
    );

    modport slave (
        input  mode, in_valid, in_last, int_in, frac1_in, frac2_in, out_ready,
        output in_ready, out_valid, out_data, sat_flag, err
    );
endinterface

// File: rtl/partial_sum_combiner.sv
// partial_sum_combiner
// Two-stage pipeline that merges per-lane integer/fraction partial products
// into saturated fixed-point results. Stage 1 forms the aligned combined value
// per lane (QK/ACC or the four-part VALUE combine); stage 2 either emits the
// saturated result or folds it into a multi-beat accumulator.
// Ports:
//   clk     rising-edge clock
//   _reset  synchronous active-high reset
//   bus     partial_sum_combiner_if.slave (beat in, result out, err)
//
// Accumulation control FSM:
//   state   | meaning
//   ST_IDLE | no ACC group open, accumulator is zero
//   ST_OPEN | ACC group in progress, accumulator holds partial sum
module partial_sum_combiner #(
    parameter int LANES     = 16,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 8,
    parameter int OUT_W     = 24,
    parameter int MAX_BEATS = 16
) (
    input logic                   clk,
    input logic                   _reset,
    partial_sum_combiner_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int HALF  = LANES / 2;
    localparam int ACC_W = 2 * WIDTH + 2 * SHIFT + $clog2(MAX_BEATS) + 2;
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    localparam logic [1:0] MODE_QK    = 2'b00;
    localparam logic [1:0] MODE_VALUE = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;

    typedef enum logic {ST_IDLE, ST_OPEN} state_t;

    function automatic logic signed [ACC_W-1:0] sx(input logic [PW-1:0] v);
        return {{(ACC_W-PW){v[PW-1]}}, v};
    endfunction

    // Returns {clamped, value}; in range iff all bits above the output sign agree.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
        if ((&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1]))
            return {1'b0, v[OUT_W-1:0]};
        else if (v[ACC_W-1])
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    logic                    adv;
    logic                    accept;

    logic signed [ACC_W-1:0] c_qk  [LANES];
    logic signed [ACC_W-1:0] c_val [LANES];

    logic                    s1_valid;
    logic [1:0]              s1_mode;
    logic                    s1_last;
    logic signed [ACC_W-1:0] s1_c  [LANES];

    state_t                  state, state_nxt;
    logic                    emit, emit_acc, acc_add, acc_clr, err_nxt;
    logic [CNT_W-1:0]        beat_cnt;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] sum_v [LANES];

    logic [LANES*OUT_W-1:0]  out_nxt;
    logic [LANES-1:0]        sat_nxt;
    logic                    out_valid_q;
    logic [LANES*OUT_W-1:0]  out_data_q;
    logic [LANES-1:0]        sat_q;
    logic                    err_q;

    assign adv           = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && adv;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;
    assign bus.err       = err_q;

    // Stage-1 combine. VALUE pairs lane i with lane i+HALF and leaves the upper half zero.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            c_qk[i]  = (sx(bus.int_in[i*PW +: PW]) <<< SHIFT)
                       + sx(bus.frac1_in[i*PW +: PW])
                       + sx(bus.frac2_in[i*PW +: PW]);
            c_val[i] = '0;
        end
        for (int i = 0; i < HALF; i++) begin
            c_val[i] = ((sx(bus.frac1_in[i*PW +: PW]) <<< (2*SHIFT))
                       + ((sx(bus.frac1_in[(i+HALF)*PW +: PW])
                           + sx(bus.frac2_in[i*PW +: PW])) <<< SHIFT)
                       + sx(bus.frac2_in[(i+HALF)*PW +: PW])) >>> SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 2'b00;
            s1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_c[i] <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_mode <= bus.mode;
                s1_last <= bus.in_last;
                for (int i = 0; i < LANES; i++)
                    s1_c[i] <= (bus.mode == MODE_VALUE) ? c_val[i] : c_qk[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Stage-2 decisions; nothing happens unless the pipe advances.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_acc  = 1'b0;
        acc_add   = 1'b0;
        acc_clr   = 1'b0;
        err_nxt   = 1'b0;
        if (adv && s1_valid) begin
            case (s1_mode)
                MODE_QK, MODE_VALUE: begin
                    emit = 1'b1;
                    if (state == ST_OPEN) begin
                        acc_clr   = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                MODE_ACC: begin
                    if (s1_last || beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        emit      = 1'b1;
                        emit_acc  = 1'b1;
                        acc_clr   = 1'b1;
                        err_nxt   = !s1_last;
                        state_nxt = ST_IDLE;
                    end else begin
                        acc_add   = 1'b1;
                        state_nxt = ST_OPEN;
                    end
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    always_comb begin
        out_nxt = '0;
        sat_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_v[i] = emit_acc ? (acc_q[i] + s1_c[i]) : s1_c[i];
            {sat_nxt[i], out_nxt[i*OUT_W +: OUT_W]} = saturate(sum_v[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= '0;
            err_q       <= 1'b0;
            beat_cnt    <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            err_q <= err_nxt;
            if (adv) begin
                out_valid_q <= emit;
                if (emit) begin
                    out_data_q <= out_nxt;
                    sat_q      <= sat_nxt;
                end
                if (acc_clr) begin
                    beat_cnt <= '0;
                    for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                end else if (acc_add) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    for (int i = 0; i < LANES; i++) acc_q[i] <= acc_q[i] + s1_c[i];
                end
            end
        end
    end
endmodule
